// File: rtl/mux12_scan_sequencer.sv
// mux12_scan_sequencer: steps a 12:1 selector through enabled channels and assembles a frame word
module mux12_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_continuous,
    input  logic [11:0] i_chan_en,
    input  logic        i_mux_o,
    output logic [3:0]  o_sel,
    output logic        o_busy,
    output logic        o_sample_valid,
    output logic        o_sample_bit,
    output logic [3:0]  o_sample_ch,
    output logic [11:0] o_frame_word,
    output logic        o_frame_done,
    output logic        o_err
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sel, r_sample_ch;
    logic [11:0]      r_mask, r_accum, r_frame_word;
    logic             r_cont, r_sample_valid, r_sample_bit, r_frame_done, r_err;
    logic [3:0]       w_first_req, w_first_mask, w_next_ch;
    logic             w_has_next, w_go, w_done, w_err;
    logic [11:0]      w_merged;

    // channel search: lowest of the request mask, lowest of the latched mask, next above sel
    always_comb begin
        w_first_req  = 4'd0;
        w_first_mask = 4'd0;
        w_next_ch    = 4'd0;
        w_has_next   = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (i_chan_en[i]) w_first_req = 4'(i);
            if (r_mask[i]) w_first_mask = 4'(i);
            if (r_mask[i] && i > int'(r_sel)) begin
                w_next_ch  = 4'(i);
                w_has_next = 1'b1;
            end
        end
    end

    assign w_go     = r_state == IDLE && i_start && !i_stop && |i_chan_en;
    assign w_err    = r_state == IDLE && i_start && !i_stop && ~|i_chan_en;
    assign w_done   = r_state == SCAN && !i_stop && r_cnt == CNT_W'(DWELL - 1);
    assign w_merged = r_accum | (12'(i_mux_o) << r_sel);

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // next state: stop always wins, a one-shot frame ends on its last channel
    always_comb begin
        w_next_state = r_state;
        if (r_state == IDLE)
            w_next_state = w_go ? SCAN : IDLE;
        else if (i_stop || (w_done && !w_has_next && !r_cont))
            w_next_state = IDLE;
    end

    // datapath: dwell counter, select, accumulation and registered result pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt          <= '0;
            r_sel          <= 4'd0;
            r_mask         <= 12'd0;
            r_cont         <= 1'b0;
            r_accum        <= 12'd0;
            r_frame_word   <= 12'd0;
            r_sample_valid <= 1'b0;
            r_sample_bit   <= 1'b0;
            r_sample_ch    <= 4'd0;
            r_frame_done   <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_sample_valid <= w_done;
            r_frame_done   <= w_done && !w_has_next;
            r_err          <= w_err;
            if (w_done) begin
                r_sample_bit <= i_mux_o;
                r_sample_ch  <= r_sel;
            end
            if (i_stop) begin
                r_cnt   <= '0;
                r_accum <= 12'd0;
            end else if (w_go) begin
                r_mask  <= i_chan_en;
                r_cont  <= i_continuous;
                r_sel   <= w_first_req;
                r_cnt   <= '0;
                r_accum <= 12'd0;
            end else if (r_state == SCAN) begin
                r_cnt <= w_done ? '0 : r_cnt + 1'b1;
                if (w_done && w_has_next) begin
                    r_accum <= w_merged;
                    r_sel   <= w_next_ch;
                end else if (w_done) begin
                    r_frame_word <= w_merged & r_mask;
                    r_accum      <= 12'd0;
                    r_sel        <= r_cont ? w_first_mask : r_sel;
                end
            end
        end
    end

    // outputs
    always_comb begin
        o_sel          = r_sel;
        o_busy         = r_state == SCAN;
        o_sample_valid = r_sample_valid;
        o_sample_bit   = r_sample_bit;
        o_sample_ch    = r_sample_ch;
        o_frame_word   = r_frame_word;
        o_frame_done   = r_frame_done;
        o_err          = r_err;
    end
endmodule
